// File: rtl/neuron_accumulator.sv
// neuron_accumulator
// Accumulates INPUT_NUMBER signed input*weight products on top of a scaled
// bias, rescales the sum by SHIFT (floor), saturates it to DATA_WIDTH bits and
// presents it as an offset-binary code with a one-cycle enable for the
// downstream sigmoid stage.
module neuron_accumulator #(
    parameter int INPUT_NUMBER = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int SHIFT        = DATA_WIDTH - 1,
    parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(INPUT_NUMBER) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_weight,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] activ_in,
    output logic                  enable,
    output logic                  busy
);

    localparam int CNT_W = (INPUT_NUMBER > 1) ? $clog2(INPUT_NUMBER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_NUMBER - 1);

    // Saturation bounds of a signed DATA_WIDTH value, held at accumulator width
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // Clamp a wide signed value into the signed DATA_WIDTH range
    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [DATA_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    state_t                         state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic signed [DATA_WIDTH-1:0]   sat_q, sat_d;
    logic [DATA_WIDTH-1:0]          activ_q, activ_d;
    logic                           enable_q, enable_d;
    logic                           in_ready_q, in_ready_d;
    logic                           busy_q, busy_d;

    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]    prod_ext_s;
    logic signed [ACC_WIDTH-1:0]    bias_ext_s;
    logic signed [ACC_WIDTH-1:0]    shifted_s;
    logic                           accept_s;

    // Full-precision product and operands sign-extended to accumulator width
    assign prod_s     = $signed(in_data) * $signed(in_weight);
    assign prod_ext_s = ACC_WIDTH'(prod_s);
    assign bias_ext_s = ACC_WIDTH'($signed(bias)) <<< SHIFT;
    assign shifted_s  = acc_q >>> SHIFT;

    // in_ready_q is high exactly while in ACCUM, so it doubles as the state qualifier
    assign accept_s = in_ready_q & in_valid;

    // Next-state and datapath update for the IDLE/ACCUM/SCALE/EMIT sequence
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sat_d    = sat_q;
        activ_d  = activ_q;
        enable_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    acc_d   = bias_ext_s;
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d   = acc_q + prod_ext_s;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = ST_SCALE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_SCALE: begin
                sat_d   = saturate(shifted_s);
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // Offset binary: invert the sign bit of the two's complement value
                activ_d  = {~sat_q[DATA_WIDTH-1], sat_q[DATA_WIDTH-2:0]};
                enable_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            sat_q      <= '0;
            activ_q    <= '0;
            enable_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            activ_q    <= activ_d;
            enable_q   <= enable_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign activ_in = activ_q;
    assign enable   = enable_q;
    assign busy     = busy_q;

endmodule
